// File: rtl/ov7670_emu_pkg.sv
// Shared types and constants for the OV7670 camera transmitter emulator:
// FSM state encoding, pattern_sel encodings and the colour-bar palette.
package ov7670_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VFRONT
  } state_t;

  localparam logic [1:0] PAT_SOLID   = 2'd0;
  localparam logic [1:0] PAT_BARS    = 2'd1;
  localparam logic [1:0] PAT_RAMP    = 2'd2;
  localparam logic [1:0] PAT_CHECKER = 2'd3;

  localparam logic [15:0] BAR_C0 = 16'hFFFF;
  localparam logic [15:0] BAR_C1 = 16'hFFE0;
  localparam logic [15:0] BAR_C2 = 16'h07FF;
  localparam logic [15:0] BAR_C3 = 16'h07E0;
  localparam logic [15:0] BAR_C4 = 16'hF81F;
  localparam logic [15:0] BAR_C5 = 16'hF800;
  localparam logic [15:0] BAR_C6 = 16'h001F;
  localparam logic [15:0] BAR_C7 = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_C0;
      3'd1:    return BAR_C1;
      3'd2:    return BAR_C2;
      3'd3:    return BAR_C3;
      3'd4:    return BAR_C4;
      3'd5:    return BAR_C5;
      3'd6:    return BAR_C6;
      default: return BAR_C7;
    endcase
  endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational RGB565 test-pattern source: maps pixel coordinate (x, y),
// the latched pattern select and the latched solid colour to one pixel.
module ov7670_pattern_gen
  import ov7670_emu_pkg::*;
#(
  parameter int H_ACTIVE = 320,
  parameter int XW       = 9,
  parameter int YW       = 8
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [1:0]    sel,
  input  logic [15:0]   fixed_color,
  output logic [15:0]   pixel
);

  // Bars are H_ACTIVE/8 wide; any remainder columns stay on the last bar.
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic [15:0] xe;
  logic [15:0] ye;
  logic [15:0] bar16;
  logic [2:0]  bar_idx;
  logic        chk;

  assign xe      = 16'(x);
  assign ye      = 16'(y);
  assign bar16   = xe / 16'(BAR_W);
  assign bar_idx = (bar16 > 16'd7) ? 3'd7 : bar16[2:0];
  assign chk     = ((xe ^ ye) & 16'h0008) != 16'h0000;

  // Select the pixel value for the active pattern.
  always_comb begin
    pixel = 16'h0000;
    case (sel)
      PAT_SOLID:   pixel = fixed_color;
      PAT_BARS:    pixel = bar_color(bar_idx);
      PAT_RAMP:    pixel = xe;
      PAT_CHECKER: pixel = chk ? 16'hFFFF : 16'h0000;
      default:     pixel = 16'h0000;
    endcase
  end

endmodule

// File: rtl/ov7670_tx_emu.sv
// OV7670-style camera transmitter emulator: free-running pclk, vsync/href
// frame timing and RGB565 test patterns sent high byte first.
// Optional build macro OV7670_EMU_CHECKSUM_EN adds a per-frame byte
// checksum on frame_sum; without it frame_sum is tied to zero.
module ov7670_tx_emu
  import ov7670_emu_pkg::*;
#(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_HALF   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] fixed_color,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic [15:0] frame_sum
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int VS_LEN   = VSYNC_LINES * LINE_LEN;
  localparam int VB_LEN   = V_BACK * LINE_LEN;
  localparam int VF_LEN   = V_FRONT * LINE_LEN;
  localparam int M1       = (VS_LEN > VB_LEN) ? VS_LEN : VB_LEN;
  localparam int M2       = (VF_LEN > H_BLANK) ? VF_LEN : H_BLANK;
  localparam int MAX_LEN  = (M1 > M2) ? M1 : M2;
  localparam int CW       = $clog2(MAX_LEN + 1);
  localparam int XW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int DW       = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;

  localparam logic [CW-1:0] VS_LAST = CW'(VS_LEN - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(VB_LEN - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VF_LAST = CW'(VF_LEN - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(PCLK_HALF - 1);

  logic [DW-1:0] div_cnt;
  logic          div_wrap;
  logic          tick;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic          phase, phase_n;
  logic          latch;
  logic          done;
  logic [1:0]    sel_q;
  logic [15:0]   color_q;
  logic [15:0]   pixel;

  assign div_wrap = (div_cnt == D_LAST);
  // A slot ends on the clk edge where pclk falls.
  assign tick     = div_wrap & pclk;

  // pclk divider: toggle pclk every PCLK_HALF clk cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      pclk    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      pclk    <= ~pclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame FSM next state: every transition and counter step happens on a tick.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = x;
    y_n     = y;
    phase_n = phase;
    latch   = 1'b0;
    done    = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state_n = ST_VSYNC;
            cnt_n   = '0;
            latch   = 1'b1;
          end
        end
        ST_VSYNC: begin
          if (cnt == VS_LAST) begin
            state_n = ST_VBACK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_VBACK: begin
          if (cnt == VB_LAST) begin
            state_n = ST_ACTIVE;
            cnt_n   = '0;
            x_n     = '0;
            y_n     = '0;
            phase_n = 1'b0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          phase_n = ~phase;
          if (phase) begin
            if (x == X_LAST) begin
              state_n = ST_HBLANK;
              cnt_n   = '0;
              x_n     = '0;
            end else begin
              x_n = x + 1'b1;
            end
          end
        end
        ST_HBLANK: begin
          if (cnt == HB_LAST) begin
            cnt_n = '0;
            if (y == Y_LAST) begin
              state_n = ST_VFRONT;
            end else begin
              state_n = ST_ACTIVE;
              y_n     = y + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_VFRONT: begin
          if (cnt == VF_LAST) begin
            done  = 1'b1;
            cnt_n = '0;
            if (enable) begin
              state_n = ST_VSYNC;
              latch   = 1'b1;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Frame FSM state, position counters and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      phase       <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      x          <= x_n;
      y          <= y_n;
      phase      <= phase_n;
      frame_done <= done;
      if (done) frame_count <= frame_count + 8'h01;
    end
  end

  // Pattern inputs are captured only at frame start so a frame is uniform.
  always_ff @(posedge clk) begin
    if (latch) begin
      sel_q   <= pattern_sel;
      color_q <= fixed_color;
    end
  end

  ov7670_pattern_gen #(
    .H_ACTIVE(H_ACTIVE),
    .XW      (XW),
    .YW      (YW)
  ) u_pattern (
    .x          (x),
    .y          (y),
    .sel        (sel_q),
    .fixed_color(color_q),
    .pixel      (pixel)
  );

  assign vsync = (state == ST_VSYNC);
  assign href  = (state == ST_ACTIVE);
  assign busy  = (state != ST_IDLE);
  assign data  = href ? (phase ? pixel[7:0] : pixel[15:8]) : 8'h00;

`ifdef OV7670_EMU_CHECKSUM_EN
  logic [15:0] acc;

  // Sum each href-high byte as its slot ends; publish the total with frame_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= 16'h0000;
      frame_sum <= 16'h0000;
    end else if (done) begin
      frame_sum <= acc;
      acc       <= 16'h0000;
    end else if (tick && href) begin
      acc <= acc + {8'h00, data};
    end
  end
`else
  assign frame_sum = 16'h0000;
`endif

endmodule
